// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master arbiter slice.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   // Index of the set bit in a one-hot vector of up to 8 clients; 0 when empty.
   function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) r = r | 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Client-side and SPI-master-side handshake bundle of the arbiter.
interface spi_master_arbiter_if #(
   parameter int unsigned SPI_DATA_WIDTH = 8,
   parameter int unsigned NUM_REQUESTERS = 4
);
   logic [NUM_REQUESTERS-1:0]                i_req;
   logic [NUM_REQUESTERS*SPI_DATA_WIDTH-1:0] i_data;
   logic [NUM_REQUESTERS-1:0]                i_last;
   logic [NUM_REQUESTERS-1:0]                o_ack;
   logic [SPI_DATA_WIDTH-1:0]                o_rx_data;
   logic [NUM_REQUESTERS-1:0]                o_grant;
   logic                                     o_busy;
   logic                                     o_spi_enable;
   logic [SPI_DATA_WIDTH-1:0]                o_spi_data;
   logic [SPI_DATA_WIDTH-1:0]                i_spi_data;
   logic                                     i_spi_done;
   logic                                     i_spi_busy;

   // Arbiter side
   modport master (
      input  i_req, i_data, i_last, i_spi_data, i_spi_done, i_spi_busy,
      output o_ack, o_rx_data, o_grant, o_busy, o_spi_enable, o_spi_data
   );

   // Clients plus SPI master side
   modport slave (
      output i_req, i_data, i_last, i_spi_data, i_spi_done, i_spi_busy,
      input  o_ack, o_rx_data, o_grant, o_busy, o_spi_enable, o_spi_data
   );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1, modulo N.
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] k;
   logic          found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      k     = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         k = IW'((32'(ptr) + i) % N);
         if (req[k] && !found) begin
            grant[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign idx = IW'(onehot_to_index(8'(grant)));

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among clients, with burst locking and hold timeout.
module spi_master_arbiter
   import spi_pkg::*;
#(
   parameter int unsigned SPI_DATA_WIDTH = 8,
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned HOLD_TIMEOUT   = 64
) (
   input logic                  i_clock,
   input logic                  i_reset,
   spi_master_arbiter_if.master bus
);

   localparam int unsigned IW = $clog2(NUM_REQUESTERS);
   localparam int unsigned CW = $clog2(HOLD_TIMEOUT);

   arb_state_t                state;
   logic [IW-1:0]             ptr;
   logic [IW-1:0]             gidx;
   logic                      last_q;
   logic [CW-1:0]             cnt;
   logic [NUM_REQUESTERS-1:0] pick_grant;
   logic [IW-1:0]             pick_idx;

   spi_rr_arbiter #(
      .N  (NUM_REQUESTERS),
      .IW (IW)
   ) u_rr (
      .req   (bus.i_req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state            <= IDLE;
         ptr              <= IW'(NUM_REQUESTERS-1);
         gidx             <= '0;
         last_q           <= 1'b0;
         cnt              <= '0;
         bus.o_ack        <= '0;
         bus.o_rx_data    <= '0;
         bus.o_grant      <= '0;
         bus.o_busy       <= 1'b0;
         bus.o_spi_enable <= 1'b0;
         bus.o_spi_data   <= '0;
      end else begin
         bus.o_ack <= '0;
         case (state)
            IDLE: begin
               if (|bus.i_req && !bus.i_spi_busy) begin
                  state            <= XFER;
                  gidx             <= pick_idx;
                  bus.o_grant      <= pick_grant;
                  bus.o_spi_data   <= bus.i_data[pick_idx*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                  last_q           <= bus.i_last[pick_idx];
                  bus.o_spi_enable <= 1'b1;
                  bus.o_busy       <= 1'b1;
               end
            end
            XFER: begin
               if (bus.i_spi_done) begin
                  bus.o_spi_enable <= 1'b0;
                  bus.o_rx_data    <= bus.i_spi_data;
                  bus.o_ack        <= bus.o_grant;
                  cnt              <= '0;
                  if (last_q) begin
                     state       <= IDLE;
                     bus.o_grant <= '0;
                     bus.o_busy  <= 1'b0;
                     ptr         <= gidx;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // The ack cycle only counts time; the owner's request is judged from the next cycle.
               if (cnt == CW'(HOLD_TIMEOUT-1) || (!(|bus.o_ack) && !bus.i_req[gidx])) begin
                  state       <= IDLE;
                  bus.o_grant <= '0;
                  bus.o_busy  <= 1'b0;
                  ptr         <= gidx;
               end else if (!(|bus.o_ack) && !bus.i_spi_busy) begin
                  state            <= XFER;
                  bus.o_spi_data   <= bus.i_data[gidx*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                  last_q           <= bus.i_last[gidx];
                  bus.o_spi_enable <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state            <= IDLE;
               bus.o_grant      <= '0;
               bus.o_busy       <= 1'b0;
               bus.o_spi_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: vector table plus burst, timeout, busy and reset sequences.
module tb_spi_master_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   spi_master_arbiter_if #(.SPI_DATA_WIDTH(8), .NUM_REQUESTERS(4)) bus ();

   spi_master_arbiter #(
      .SPI_DATA_WIDTH (8),
      .NUM_REQUESTERS (4),
      .HOLD_TIMEOUT   (8)
   ) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  last;
      logic        done;
      logic        busy;
      logic [7:0]  rxin;
      logic        en;
      logic [3:0]  grant;
      logic [3:0]  ack;
      logic [7:0]  rx;
      logic [7:0]  sd;
      logic        obusy;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [3:0] req, input logic [31:0] data, input logic [3:0] last,
                      input logic done, input logic busy, input logic [7:0] rxin,
                      input logic en, input logic [3:0] grant, input logic [3:0] ack,
                      input logic [7:0] rx, input logic [7:0] sd, input logic obusy);
      vec_t v;
      v.req = req; v.data = data; v.last = last; v.done = done; v.busy = busy; v.rxin = rxin;
      v.en = en; v.grant = grant; v.ack = ack; v.rx = rx; v.sd = sd; v.obusy = obusy;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic [31:0] data, input logic [3:0] last,
                        input logic done, input logic busy, input logic [7:0] rxin);
      bus.i_req      = req;
      bus.i_data     = data;
      bus.i_last     = last;
      bus.i_spi_done = done;
      bus.i_spi_busy = busy;
      bus.i_spi_data = rxin;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);

      // Round-robin, all clients requesting single words; client k word is 8'h11*(k+1)
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h1, 4'h0, 8'h00, 8'h11, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA0, 0, 4'h0, 4'h1, 8'hA0, 8'h11, 0);
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h2, 4'h0, 8'hA0, 8'h22, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA1, 0, 4'h0, 4'h2, 8'hA1, 8'h22, 0);
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h4, 4'h0, 8'hA1, 8'h33, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA2, 0, 4'h0, 4'h4, 8'hA2, 8'h33, 0);
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h8, 4'h0, 8'hA2, 8'h44, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA3, 0, 4'h0, 4'h8, 8'hA3, 8'h44, 0);
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h1, 4'h0, 8'hA3, 8'h11, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA4, 0, 4'h0, 4'h1, 8'hA4, 8'h11, 0);
      add(4'hF, 32'h44332211, 4'hF, 0, 0, 8'h00, 1, 4'h2, 4'h0, 8'hA4, 8'h22, 1);
      add(4'hF, 32'h44332211, 4'hF, 1, 0, 8'hA5, 0, 4'h0, 4'h2, 8'hA5, 8'h22, 0);
      add(4'h0, 32'h44332211, 4'hF, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'hA5, 8'h22, 0);
      // Single word from client 1: tx A5, master returns 3C
      add(4'h2, 32'h0000A500, 4'h2, 0, 0, 8'h00, 1, 4'h2, 4'h0, 8'hA5, 8'hA5, 1);
      add(4'h2, 32'h0000A500, 4'h2, 0, 0, 8'h00, 1, 4'h2, 4'h0, 8'hA5, 8'hA5, 1);
      add(4'h2, 32'h0000A500, 4'h2, 1, 0, 8'h3C, 0, 4'h0, 4'h2, 8'h3C, 8'hA5, 0);
      add(4'h0, 32'h0000A500, 4'h2, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h3C, 8'hA5, 0);
      // Stray done in IDLE
      add(4'h0, 32'h0000A500, 4'h2, 1, 0, 8'h77, 0, 4'h0, 4'h0, 8'h3C, 8'hA5, 0);

      // Reset state
      step();
      check("reset_en",    32'(bus.o_spi_enable), 32'h0);
      check("reset_grant", 32'(bus.o_grant),      32'h0);
      check("reset_ack",   32'(bus.o_ack),        32'h0);
      check("reset_busy",  32'(bus.o_busy),       32'h0);
      check("reset_rx",    32'(bus.o_rx_data),    32'h0);
      check("reset_sd",    32'(bus.o_spi_data),   32'h0);
      #2 rst = 1'b0;

      foreach (vt[i]) begin
         drive(vt[i].req, vt[i].data, vt[i].last, vt[i].done, vt[i].busy, vt[i].rxin);
         step();
         check($sformatf("vec%0d_en", i),    32'(bus.o_spi_enable), 32'(vt[i].en));
         check($sformatf("vec%0d_grant", i), 32'(bus.o_grant),      32'(vt[i].grant));
         check($sformatf("vec%0d_ack", i),   32'(bus.o_ack),        32'(vt[i].ack));
         check($sformatf("vec%0d_rx", i),    32'(bus.o_rx_data),    32'(vt[i].rx));
         check($sformatf("vec%0d_sd", i),    32'(bus.o_spi_data),   32'(vt[i].sd));
         check($sformatf("vec%0d_busy", i),  32'(bus.o_busy),       32'(vt[i].obusy));
      end

      // Burst: client 2 sends 11,22,33 while client 0 waits
      drive(4'h5, 32'h00110055, 4'h1, 0, 0, 8'h00);
      step();
      check("burst_g1", 32'(bus.o_grant), 32'h4);
      check("burst_sd1", 32'(bus.o_spi_data), 32'h11);
      drive(4'h5, 32'h00110055, 4'h1, 1, 0, 8'hB1);
      step();
      check("burst_ack1", 32'(bus.o_ack), 32'h4);
      check("burst_rx1", 32'(bus.o_rx_data), 32'hB1);
      check("burst_hold1", 32'(bus.o_grant), 32'h4);
      drive(4'h5, 32'h00220055, 4'h1, 0, 0, 8'h00);
      step();
      check("burst_ackcyc_en", 32'(bus.o_spi_enable), 32'h0);
      step();
      check("burst_en2", 32'(bus.o_spi_enable), 32'h1);
      check("burst_sd2", 32'(bus.o_spi_data), 32'h22);
      check("burst_g2", 32'(bus.o_grant), 32'h4);
      drive(4'h5, 32'h00220055, 4'h1, 1, 0, 8'hB2);
      step();
      check("burst_ack2", 32'(bus.o_ack), 32'h4);
      check("burst_rx2", 32'(bus.o_rx_data), 32'hB2);
      drive(4'h5, 32'h00330055, 4'h5, 0, 0, 8'h00);
      step();
      step();
      check("burst_sd3", 32'(bus.o_spi_data), 32'h33);
      check("burst_g3", 32'(bus.o_grant), 32'h4);
      drive(4'h5, 32'h00330055, 4'h5, 1, 0, 8'hB3);
      step();
      check("burst_ack3", 32'(bus.o_ack), 32'h4);
      check("burst_rel", 32'(bus.o_grant), 32'h0);
      drive(4'h1, 32'h00330055, 4'h5, 0, 0, 8'h00);
      step();
      check("burst_next_g", 32'(bus.o_grant), 32'h1);
      check("burst_next_sd", 32'(bus.o_spi_data), 32'h55);
      drive(4'h1, 32'h00330055, 4'h5, 1, 0, 8'hB4);
      step();
      check("burst_next_ack", 32'(bus.o_ack), 32'h1);
      drive(4'h0, 32'h0, 4'h0, 0, 0, 8'h00);
      step();

      // Timeout: client 3 holds without re-presenting (master busy), client 0 waits
      drive(4'h9, 32'hC3000055, 4'h1, 0, 0, 8'h00);
      step();
      check("to_g", 32'(bus.o_grant), 32'h8);
      check("to_sd", 32'(bus.o_spi_data), 32'hC3);
      drive(4'h9, 32'hC3000055, 4'h1, 1, 1, 8'hD3);
      step();
      check("to_ack", 32'(bus.o_ack), 32'h8);
      for (int i = 1; i <= 7; i++) begin
         drive(4'h9, 32'hC3000055, 4'h1, (i == 3), 1, (i == 3) ? 8'hEE : 8'h00);
         step();
         check($sformatf("to_hold%0d_g", i), 32'(bus.o_grant), 32'h8);
         check($sformatf("to_hold%0d_ack", i), 32'(bus.o_ack), 32'h0);
      end
      check("to_stray_rx", 32'(bus.o_rx_data), 32'hD3);
      drive(4'h9, 32'hC3000055, 4'h1, 0, 1, 8'h00);
      step();
      check("to_release", 32'(bus.o_grant), 32'h0);
      check("to_busy", 32'(bus.o_busy), 32'h0);
      drive(4'h9, 32'hC3000055, 4'h1, 0, 0, 8'h00);
      step();
      check("to_next_g", 32'(bus.o_grant), 32'h1);
      check("to_next_sd", 32'(bus.o_spi_data), 32'h55);
      drive(4'h9, 32'hC3000055, 4'h1, 1, 0, 8'hD4);
      step();
      check("to_next_ack", 32'(bus.o_ack), 32'h1);
      drive(4'h0, 32'h0, 4'h0, 0, 0, 8'h00);
      step();

      // Busy gating
      drive(4'h1, 32'h00000055, 4'h1, 0, 1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("busy_wait%0d_en", i), 32'(bus.o_spi_enable), 32'h0);
      end
      drive(4'h1, 32'h00000055, 4'h1, 0, 0, 8'h00);
      step();
      check("busy_fall_en", 32'(bus.o_spi_enable), 32'h1);
      check("busy_fall_g", 32'(bus.o_grant), 32'h1);
      drive(4'h1, 32'h00000055, 4'h1, 1, 0, 8'hE1);
      step();
      check("busy_ack", 32'(bus.o_ack), 32'h1);
      check("busy_rx", 32'(bus.o_rx_data), 32'hE1);
      drive(4'h0, 32'h0, 4'h0, 0, 0, 8'h00);
      step();

      // Reset mid-XFER, then client 0 has first priority
      drive(4'h4, 32'h00770055, 4'h5, 0, 0, 8'h00);
      step();
      check("rst_pre_g", 32'(bus.o_grant), 32'h4);
      check("rst_pre_en", 32'(bus.o_spi_enable), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_en", 32'(bus.o_spi_enable), 32'h0);
      check("rst_async_g", 32'(bus.o_grant), 32'h0);
      check("rst_async_ack", 32'(bus.o_ack), 32'h0);
      drive(4'h5, 32'h00770055, 4'h5, 0, 0, 8'h00);
      #2 rst = 1'b0;
      step();
      check("rst_after_g", 32'(bus.o_grant), 32'h1);
      check("rst_after_sd", 32'(bus.o_spi_data), 32'h55);
      drive(4'h5, 32'h00770055, 4'h5, 1, 0, 8'hF0);
      step();
      check("rst_after_ack", 32'(bus.o_ack), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
